scan_keypad_hex: RTL and testbench
==================================

// Module: scan_keypad_hex
// PURPOSE
//  Input-side counterpart of the scanned 4-digit 7-seg display driver: scans a 4x4 hex matrix keypad.
//  Drives rows one at a time (active-low), samples columns, debounces over whole scan frames,
//  and delivers one 4-bit hex code per press over a valid/ready handshake, e.g. to feed hexN of the display.
// PARAMETERS
//  SCAN_DIV_W       12  row slot = 2**SCAN_DIV_W clk cycles; frame = 4 slots
//  DEBOUNCE_FRAMES   3  consecutive identical frames needed to accept a press or a release (>=1, <=15)
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  row_n        out  4  keypad row drive, one row low per slot (1110,1101,1011,0111)
//  col_n        in   4  keypad column sense, asynchronous, pulled up, low = key closed
//  key_code     out  4  accepted key, code = {row[1:0],col[1:0]} (row r, col c -> 4*r+c)
//  key_valid    out  1  key_code holds an unconsumed key
//  key_ready    in   1  consumer accepts key_code when key_valid & key_ready
//  key_pressed  out  1  level: a debounced key is currently held
//  overrun      out  1  sticky: a new key overwrote an unconsumed one
//  ovr_clr      in   1  one-cycle pulse, clears overrun
// BEHAVIOUR
//  Reset (async assert, sync release): row_n=1110, key_code=0, key_valid=0, key_pressed=0, overrun=0,
//   divider=0, row index=0, FSM=IDLE, all frame/debounce counters 0.
//  Scan: free-running SCAN_DIV_W-bit divider; row index advances 0->1->2->3->0 when divider wraps.
//  col_n passes through a 2-flop synchronizer; sampled on the last cycle of each slot (divider all-ones).
//  Frame result, evaluated at end of slot 3: NONE (no closure), KEY(k) (exactly one closure in frame),
//   MULTI (two or more closures anywhere in frame); MULTI treated as "not a valid key".
//  FSM, transitions only at frame end:
//   IDLE:     KEY(k) -> DEBOUNCE, cand=k, cnt=1 (DEBOUNCE_FRAMES=1: accept immediately -> HELD).
//   DEBOUNCE: result==KEY(cand): cnt++; when cnt==DEBOUNCE_FRAMES -> accept, HELD.
//             any other result -> IDLE, cnt=0.
//   HELD:     key_pressed=1. NONE: rel++; rel==DEBOUNCE_FRAMES -> IDLE. Otherwise rel=0, stay (no auto-repeat).
//  Accept: key_code<=cand, key_valid<=1 in the cycle after the frame-end edge.
//  Handshake: key_valid & key_ready -> key_valid=0 next cycle; key_code held until next accept.
//   Accept while key_valid & !key_ready: key_code overwritten, overrun<=1.
//   Accept in same cycle as key_valid & key_ready: new key wins, key_valid stays 1, no overrun.
//   ovr_clr with simultaneous overrun set: set wins.
//  Latency: stable press -> key_valid within (DEBOUNCE_FRAMES+1) frames + 3 cycles.
//  Reset mid-operation: partially debounced candidate discarded; key still held after release
//   re-qualifies from IDLE and produces a fresh event.
// STRUCTURE
//  Shared package kbd_pkg: FSM state enum (IDLE/DEBOUNCE/HELD), frame-result enum
//   (NONE/KEY/MULTI), ROW_DRIVE[0:3] constant table, code packing function {row,col}.
//  Sub-module sync_2ff (width param, async active-low reset to all-ones) for col_n.
//  Top holds divider, row counter, frame accumulator, debounce FSM, output handshake register.
// TESTING  (sim with SCAN_DIV_W=2 -> 4-cycle slot, 16-cycle frame; DEBOUNCE_FRAMES=3)
//  Reset: rst_n=0 mid-slot -> row_n=1110 and all outputs 0 immediately; release -> row_n steps 1101 at cycle 4.
//  Press: col_n[1]=0 only while row_n==1011, 6 frames, key_ready=0 -> single key_valid, key_code=4'h9, key_pressed=1.
//  Bounce: same key alternating present/absent every frame for 10 frames -> key_valid never asserts.
//  Multi: keys 4'h0 and 4'hF held together 6 frames -> no event; release 4'hF -> 4'h0 accepted after 3 frames.
//  Overrun: key_ready=0, accept 4'h5, release, accept 4'h7 -> key_code=7, overrun=1; ovr_clr pulse -> 0;
//   key_ready=1 one cycle -> key_valid=0 next cycle, key_code stays 7.
//  Reset in DEBOUNCE (cnt=2) with key held -> no event at reset; after release of rst_n key re-accepted after 3 frames.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner: FSM state encoding,
// per-frame scan result, row drive pattern table and key code packing.
package kbd_pkg;

    typedef logic [1:0] kbd_state_t;
    localparam kbd_state_t ST_IDLE     = 2'd0;
    localparam kbd_state_t ST_DEBOUNCE = 2'd1;
    localparam kbd_state_t ST_HELD     = 2'd2;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } frame_res_e;

    // Active-low row drive, indexed by the row being scanned.
    localparam logic [3:0] ROW_DRIVE [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    function automatic logic [3:0] pack_code(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones so that
// pulled-up, active-low inputs read as idle while in reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/scan_keypad_hex.sv
// 4x4 hex keypad scanner: row-at-a-time drive, whole-frame debounce of presses and
// releases, one key code per press delivered on a valid/ready output register.
module scan_keypad_hex
    import kbd_pkg::*;
#(
    parameter int SCAN_DIV_W      = 12,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row_n,
    input  logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_pressed,
    output logic       overrun,
    input  logic       ovr_clr,
    output logic [1:0] dbg_state_o
);

    localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

    logic [SCAN_DIV_W-1:0] div_q, div_d;
    logic [1:0]            row_q, row_d;
    logic [3:0]            col_s;
    logic [3:0]            closed;
    logic                  slot_end;
    logic                  frame_end;
    logic [1:0]            slot_hits;
    logic [1:0]            slot_col;
    logic [1:0]            acc_hits_q, acc_hits_d;
    logic [3:0]            acc_code_q, acc_code_d;
    logic [2:0]            tot_hits;
    logic [3:0]            frame_code;
    frame_res_e            frame_res;
    kbd_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            rel_q, rel_d;
    logic [3:0]            cand_q, cand_d;
    logic                  accept;
    logic [3:0]            key_code_q, key_code_d;
    logic                  key_valid_q, key_valid_d;
    logic                  overrun_q, overrun_d;

    sync_2ff #(.WIDTH(4)) u_col_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (col_n),
        .q_o  (col_s)
    );

    assign closed    = ~col_s;
    assign slot_end  = &div_q;
    assign frame_end = slot_end && (row_q == 2'd3);
    assign div_d     = div_q + SCAN_DIV_W'(1);
    assign row_d     = slot_end ? row_q + 2'd1 : row_q;

    // Closures seen in the current slot, saturated at two (two already means MULTI).
    always_comb begin
        slot_hits = 2'd0;
        slot_col  = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (closed[c]) begin
                if (slot_hits != 2'd2) slot_hits = slot_hits + 2'd1;
                slot_col = 2'(c);
            end
        end
    end

    assign tot_hits   = {1'b0, acc_hits_q} + {1'b0, slot_hits};
    assign frame_code = (acc_hits_q != 2'd0) ? acc_code_q : pack_code(row_q, slot_col);

    always_comb begin
        if (tot_hits == 3'd0)      frame_res = RES_NONE;
        else if (tot_hits == 3'd1) frame_res = RES_KEY;
        else                       frame_res = RES_MULTI;
    end

    always_comb begin
        acc_hits_d = acc_hits_q;
        acc_code_d = acc_code_q;
        if (frame_end) begin
            acc_hits_d = 2'd0;
            acc_code_d = 4'd0;
        end else if (slot_end) begin
            acc_hits_d = (tot_hits > 3'd2) ? 2'd2 : tot_hits[1:0];
            acc_code_d = frame_code;
        end
    end

    // Debounce FSM; it only moves on frame boundaries.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_res == RES_KEY) begin
                        cand_d = frame_code;
                        if (DF == 4'd1) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                            cnt_d   = 4'd0;
                            rel_d   = 4'd0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame_res == RES_KEY && frame_code == cand_q) begin
                        if (cnt_q + 4'd1 == DF) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                            cnt_d   = 4'd0;
                            rel_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                ST_HELD: begin
                    if (frame_res == RES_NONE) begin
                        if (rel_q + 4'd1 == DF) begin
                            state_d = ST_IDLE;
                            rel_d   = 4'd0;
                        end else begin
                            rel_d = rel_q + 4'd1;
                        end
                    end else begin
                        rel_d = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    rel_d   = 4'd0;
                end
            endcase
        end
    end

    // Handshake: a key is transferred on any cycle with key_valid & key_ready; key_valid
    // then drops unless a new key is accepted that same cycle (new key wins, no overrun).
    // Accepting over an untaken key overwrites it and sets sticky overrun (set beats ovr_clr).
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        if (ovr_clr) overrun_d = 1'b0;
        if (accept) begin
            key_code_d  = cand_d;
            key_valid_d = 1'b1;
            if (key_valid_q && !key_ready) overrun_d = 1'b1;
        end else if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            row_q       <= 2'd0;
            acc_hits_q  <= 2'd0;
            acc_code_q  <= 4'd0;
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            rel_q       <= 4'd0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            div_q       <= div_d;
            row_q       <= row_d;
            acc_hits_q  <= acc_hits_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign row_n       = ROW_DRIVE[row_q];
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = (state_q == ST_HELD);
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_scan_keypad_hex.sv
// Bench for scan_keypad_hex with a 16-cycle scan frame: frame-level vector table,
// hand-written handshake/reset sequences, then random key activity against a frame model.
module tb_scan_keypad_hex;

    localparam int DF    = 3;
    localparam int FRAME = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_pressed;
    logic        overrun;
    logic        ovr_clr;
    logic [1:0]  dbg_state;

    logic [15:0] held;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] mask;
        logic        rdy;
        logic        exp_valid;
        logic [3:0]  exp_code;
        logic        exp_pressed;
        logic        exp_ovr;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] exp_q[$];

    // Frame-level reference model state
    logic       m_pressed, m_valid, m_ovr, ev;
    logic [3:0] m_code, m_cand, idx;
    int         streak, none_run, nkeys;

    scan_keypad_hex #(.SCAN_DIV_W(2), .DEBOUNCE_FRAMES(DF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_n      (row_n),
        .col_n      (col_n),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_pressed(key_pressed),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Keypad matrix: key 4*r+c shorts row r to column c.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row_n[r])
                for (int c = 0; c < 4; c++)
                    if (held[4*r+c]) col_n[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frame(input logic [15:0] mask, input logic rdy,
                             input logic rdy_last, input logic clr_last);
        held      = mask;
        key_ready = rdy;
        ovr_clr   = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            if (i == FRAME - 1) begin
                key_ready = rdy_last;
                ovr_clr   = clr_last;
            end
            @(posedge clk);
            #1;
        end
        ovr_clr = 1'b0;
    endtask

    task automatic addv(input logic [15:0] m, input logic r, input logic v,
                        input logic [3:0] c, input logic p, input logic o);
        vec_t e;
        e.mask = m; e.rdy = r; e.exp_valid = v; e.exp_code = c; e.exp_pressed = p; e.exp_ovr = o;
        tbl.push_back(e);
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [3:0] c,
                              input logic p, input logic o);
        check({tag, "_valid"},   key_valid,   v);
        check({tag, "_code"},    key_code,    c);
        check({tag, "_pressed"}, key_pressed, p);
        check({tag, "_ovr"},     overrun,     o);
    endtask

    task automatic model_frame(input logic [15:0] mask, input logic rdy);
        nkeys = $countones(mask);
        idx   = 4'd0;
        for (int k = 15; k >= 0; k--) if (mask[k]) idx = 4'(k);
        ev = 1'b0;
        if (rdy) m_valid = 1'b0;
        if (!m_pressed) begin
            if (streak > 0) begin
                if (nkeys == 1 && idx == m_cand) streak++;
                else streak = 0;
            end else if (nkeys == 1) begin
                streak = 1;
                m_cand = idx;
            end
            if (streak == DF) begin
                ev        = 1'b1;
                m_pressed = 1'b1;
                streak    = 0;
                none_run  = 0;
            end
        end else begin
            if (nkeys == 0) begin
                none_run++;
                if (none_run == DF) begin
                    m_pressed = 1'b0;
                    none_run  = 0;
                end
            end else begin
                none_run = 0;
            end
        end
        if (ev) begin
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_code  = m_cand;
            exp_q.push_back(m_cand);
        end
    endtask

    initial begin
        logic [15:0] mask, prev;
        logic        rdy;
        int          mode;

        // Press 9 (row 2, col 1) for 6 frames, then release and consume
        for (int i = 0; i < 2; i++) addv(16'h0200, 0, 0, 4'h0, 0, 0);
        for (int i = 0; i < 4; i++) addv(16'h0200, 0, 1, 4'h9, 1, 0);
        for (int i = 0; i < 2; i++) addv(16'h0000, 0, 1, 4'h9, 1, 0);
        addv(16'h0000, 0, 1, 4'h9, 0, 0);
        addv(16'h0000, 1, 0, 4'h9, 0, 0);
        // 0 and F together, then F released
        for (int i = 0; i < 6; i++) addv(16'h8001, 1, 0, 4'h9, 0, 0);
        for (int i = 0; i < 2; i++) addv(16'h0001, 1, 0, 4'h9, 0, 0);
        addv(16'h0001, 1, 1, 4'h0, 1, 0);
        for (int i = 0; i < 2; i++) addv(16'h0000, 1, 0, 4'h0, 1, 0);
        addv(16'h0000, 1, 0, 4'h0, 0, 0);
        // Bouncing key never qualifies
        for (int i = 0; i < 5; i++) begin
            addv(16'h0200, 0, 0, 4'h0, 0, 0);
            addv(16'h0000, 0, 0, 4'h0, 0, 0);
        end
        // 5 accepted and left untaken, then 7 overwrites it
        for (int i = 0; i < 2; i++) addv(16'h0020, 0, 0, 4'h0, 0, 0);
        addv(16'h0020, 0, 1, 4'h5, 1, 0);
        for (int i = 0; i < 2; i++) addv(16'h0000, 0, 1, 4'h5, 1, 0);
        addv(16'h0000, 0, 1, 4'h5, 0, 0);
        for (int i = 0; i < 2; i++) addv(16'h0080, 0, 1, 4'h5, 0, 0);
        addv(16'h0080, 0, 1, 4'h7, 1, 1);

        rst_n = 1'b0; held = 16'h0; key_ready = 1'b0; ovr_clr = 1'b0;
        cycles(3);
        check_outs("reset", 1'b0, 4'h0, 1'b0, 1'b0);
        check("reset_row", row_n, 4'b1110);
        check("reset_state", dbg_state, 2'd0);
        @(negedge clk) rst_n = 1'b1;
        cycles(3);
        check("row_hold", row_n, 4'b1110);
        cycles(1);
        check("row_step", row_n, 4'b1101);
        cycles(2);
        #2 rst_n = 1'b0;
        #1 check("async_rst_row", row_n, 4'b1110);
        check_outs("async_rst", 1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        cycles(FRAME);

        foreach (tbl[i]) begin
            run_frame(tbl[i].mask, tbl[i].rdy, tbl[i].rdy, 1'b0);
            check_outs($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_code,
                       tbl[i].exp_pressed, tbl[i].exp_ovr);
        end

        // ovr_clr pulse and one-cycle consume inside a release frame
        held = 16'h0; key_ready = 1'b0;
        cycles(4);
        ovr_clr = 1'b1; cycles(1); ovr_clr = 1'b0;
        check("ovr_clr", overrun, 1'b0);
        check("ovr_clr_valid", key_valid, 1'b1);
        key_ready = 1'b1; cycles(1); key_ready = 1'b0;
        check("consume_valid", key_valid, 1'b0);
        check("consume_code", key_code, 4'h7);
        cycles(10);
        check("rel1_pressed", key_pressed, 1'b1);
        for (int i = 0; i < 2; i++) run_frame(16'h0, 0, 0, 0);
        check("rel3_pressed", key_pressed, 1'b0);

        // Overrun set and ovr_clr in the same cycle: set wins
        for (int i = 0; i < 3; i++) run_frame(16'h0004, 0, 0, 0);
        check_outs("key2", 1'b1, 4'h2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) run_frame(16'h0, 0, 0, 0);
        for (int i = 0; i < 2; i++) run_frame(16'h0400, 0, 0, 0);
        run_frame(16'h0400, 0, 0, 1);
        check_outs("set_wins", 1'b1, 4'hA, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) run_frame(16'h0, 0, 0, 0);
        run_frame(16'h0, 0, 0, 1);
        check_outs("clr_idle", 1'b1, 4'hA, 1'b0, 1'b0);

        // Accept coinciding with a transfer of the pending key
        for (int i = 0; i < 2; i++) run_frame(16'h4000, 0, 0, 0);
        run_frame(16'h4000, 0, 1, 0);
        check_outs("same_cycle", 1'b1, 4'hE, 1'b1, 1'b0);

        // Reset while debouncing key 3, key kept held across reset
        for (int i = 0; i < 3; i++) run_frame(16'h0, 0, 0, 0);
        for (int i = 0; i < 2; i++) run_frame(16'h0008, 0, 0, 0);
        check_outs("deb_pending", 1'b1, 4'hE, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_outs("deb_reset", 1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 2; i++) run_frame(16'h0008, 0, 0, 0);
        check_outs("requal_early", 1'b0, 4'h0, 1'b0, 1'b0);
        run_frame(16'h0008, 0, 0, 0);
        check_outs("requal", 1'b1, 4'h3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) run_frame(16'h0, 1, 1, 0);
        check_outs("to_random", 1'b0, 4'h3, 1'b0, 1'b0);

        // Random key activity against the frame model
        m_pressed = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_code = 4'h3; m_cand = 4'h0;
        streak = 0; none_run = 0; prev = 16'h0;
        for (int f = 0; f < 80; f++) begin
            mode = $urandom_range(0, 9);
            if (mode < 5)      mask = prev;
            else if (mode < 7) mask = 16'h0;
            else if (mode < 9) mask = 16'(1) << $urandom_range(0, 15);
            else               mask = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            rdy  = ($urandom_range(0, 3) == 0);
            prev = mask;
            run_frame(mask, rdy, rdy, 0);
            model_frame(mask, rdy);
            check_outs($sformatf("rnd%0d", f), m_valid, m_code, m_pressed, m_ovr);
            if (ev) begin
                if (exp_q.size() == 0) check($sformatf("rnd%0d_queue", f), 1, 0);
                else check($sformatf("rnd%0d_event", f), key_code, exp_q.pop_front());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
